// File: rtl/gca_pkg.sv
// Shared definitions for the gray_conv_arbiter slice: parameter defaults and the
// Gray-to-binary conversion used by the shared conversion stage.
package gca_pkg;

    localparam int GCA_NREQ_DEF = 4;
    localparam int GCA_WIDTH_DEF = 4;
    localparam int GCA_CNT_W = 16;
    localparam int GCA_MAX_W = 32;

    // Callers zero-extend into GCA_MAX_W and cast the result back to their width;
    // zero upper bits leave the low bits of the prefix-XOR untouched.
    function automatic logic [GCA_MAX_W-1:0] gray2bin(input logic [GCA_MAX_W-1:0] g);
        logic [GCA_MAX_W-1:0] b;
        b = '0;
        b[GCA_MAX_W-1] = g[GCA_MAX_W-1];
        for (int k = GCA_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gca_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// modulo NREQ. Outputs a one-hot grant, its index and an any-grant flag.
module gca_rr_pick
    import gca_pkg::*;
#(
    parameter int NREQ = GCA_NREQ_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // NOTE: every output gets a default before the scan so no latch is inferred.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j = 0;
        for (int off = 0; off < NREQ; off++) begin
            j = (int'(ptr) + off) % NREQ;
            if (en && !any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with a one-deep registered output.
// Optional accepted-request counter on grant_cnt when GCA_CNT_EN is defined.
module gray_conv_arbiter
    import gca_pkg::*;
#(
    parameter int NREQ = GCA_NREQ_DEF,
    parameter int WIDTH = GCA_WIDTH_DEF,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_binary,
    output logic [IDW-1:0]        rsp_id,
`ifdef GCA_CNT_EN
    input  logic                  rsp_ready,
    output logic [GCA_CNT_W-1:0]  grant_cnt
`else
    input  logic                  rsp_ready
`endif
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    logic             can_load;
    logic [WIDTH-1:0] win_gray;

    // Grants stay low during reset so no handshake completes in a reset cycle.
    assign can_load = (!rsp_valid || rsp_ready) && rst_n;

    gca_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (can_load),
        .gnt (req_ready),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_gray = req_gray[win_idx*WIDTH +: WIDTH];

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_binary <= '0;
            rsp_id     <= '0;
            rr_ptr     <= '0;
        end else if (win_any) begin
            rsp_valid  <= 1'b1;
            rsp_binary <= WIDTH'(gray2bin(GCA_MAX_W'(win_gray)));
            rsp_id     <= win_idx;
            rr_ptr     <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef GCA_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (win_any && grant_cnt != '1) begin
            grant_cnt <= grant_cnt + GCA_CNT_W'(1);
        end
    end
`endif

endmodule
